// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore state machine sequencing the datapath,
// plus the combinational ALU decoder and the branch-qualified PC enable.
module mips_mc_controller #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroimm,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       halted,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11,
    ORIEX   = 4'd12,
    HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  state_t     state;
  state_t     state_next;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       is_bne;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:    state_next = MEMADR;
          OP_RTYPE:        state_next = EXECUTE;
          OP_BEQ, OP_BNE:  state_next = BRANCH;
          OP_ADDI:         state_next = ADDIEX;
          OP_ORI:          state_next = ORIEX;
          OP_J:            state_next = JUMP;
          default:         state_next = ILLEGAL_TRAP ? HALT : FETCH;
        endcase
      end
      // MEMADR is shared by lw and sw; only lw goes on to read
      MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = MEMWB;
      EXECUTE: state_next = ALUWB;
      ADDIEX:  state_next = IMMWB;
      ORIEX:   state_next = IMMWB;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    zeroimm  = 1'b0;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zeroimm = 1'b1;
        aluop   = ALUOP_OR;
      end
      MEMRD: iord = 1'b1;
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      IMMWB: regwrite = 1'b1;
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase

    // Architectural write strobes are suppressed for the whole reset cycle
    if (reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      ALUOP_ADD: alucontrol = 3'b010;
      ALUOP_SUB: alucontrol = 3'b110;
      ALUOP_OR:  alucontrol = 3'b001;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
    endcase
  end

  // bne inverts the sense of zero; the branch resolves in the BRANCH cycle itself
  assign is_bne    = (op == OP_BNE);
  assign pcen      = pcwrite | (branch & (zero ^ is_bne));
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: directed instruction sequences push
// hand-computed per-cycle control words; a negedge monitor pops and compares.
module tb_mips_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb;
  logic       zeroimm;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       halted;
  logic [3:0] state_dbg;

  mips_mc_controller #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .zeroimm(zeroimm), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .halted(halted), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
  //  alusrcb, zeroimm, pcsrc, alucontrol, halted}
  logic [20:0] got;
  assign got = {state_dbg, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                alusrca, alusrcb, zeroimm, pcsrc, alucontrol, halted};

  localparam logic [20:0] E_FETCH     = {4'd0,  4'b1010, 4'b0000, 2'b01, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_FETCH_RST = {4'd0,  4'b0000, 4'b0000, 2'b01, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_DECODE    = {4'd1,  4'b0000, 4'b0000, 2'b11, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_MEMADR    = {4'd2,  4'b0000, 4'b0001, 2'b10, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_MEMRD     = {4'd3,  4'b0000, 4'b1000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_MEMWB     = {4'd4,  4'b0001, 4'b0100, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_MEMWB_RST = {4'd4,  4'b0000, 4'b0100, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_MEMWR     = {4'd5,  4'b0100, 4'b1000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_MEMWR_RST = {4'd5,  4'b0000, 4'b1000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_EX_SUB    = {4'd6,  4'b0000, 4'b0001, 2'b00, 1'b0, 2'b00, 3'b110, 1'b0};
  localparam logic [20:0] E_EX_SLT    = {4'd6,  4'b0000, 4'b0001, 2'b00, 1'b0, 2'b00, 3'b111, 1'b0};
  localparam logic [20:0] E_EX_AND    = {4'd6,  4'b0000, 4'b0001, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [20:0] E_EX_DFLT   = {4'd6,  4'b0000, 4'b0001, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_ALUWB     = {4'd7,  4'b0001, 4'b0010, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_BR_TAKEN  = {4'd8,  4'b1000, 4'b0001, 2'b00, 1'b0, 2'b01, 3'b110, 1'b0};
  localparam logic [20:0] E_BR_NOT    = {4'd8,  4'b0000, 4'b0001, 2'b00, 1'b0, 2'b01, 3'b110, 1'b0};
  localparam logic [20:0] E_ADDIEX    = {4'd9,  4'b0000, 4'b0001, 2'b10, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_IMMWB     = {4'd10, 4'b0001, 4'b0000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0};
  localparam logic [20:0] E_JUMP      = {4'd11, 4'b1000, 4'b0000, 2'b00, 1'b0, 2'b10, 3'b010, 1'b0};
  localparam logic [20:0] E_ORIEX     = {4'd12, 4'b0000, 4'b0001, 2'b10, 1'b1, 2'b00, 3'b001, 1'b0};
  localparam logic [20:0] E_HALT      = {4'd15, 4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b1};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    string       name;
    logic [20:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t item;
  int   checks   = 0;
  int   failures = 0;

  // Inputs for a cycle are applied just after the edge that entered the state
  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input logic r, input logic [20:0] e, input string nm);
    exp_t it;
    @(posedge clk);
    #1;
    op = o; funct = f; zero = z; reset = r;
    it.name = nm;
    it.exp  = e;
    q.push_back(it);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item = q.pop_front();
      checks++;
      if (got !== item.exp) begin
        failures++;
        $display("FAIL %s: got=%06b_%08b_%02b_%0b_%02b_%03b_%0b required=%06b_%08b_%02b_%0b_%02b_%03b_%0b",
                 item.name, got[20:17], got[16:9], got[8:7], got[6], got[5:4], got[3:1], got[0],
                 item.exp[20:17], item.exp[16:9], item.exp[8:7], item.exp[6], item.exp[5:4],
                 item.exp[3:1], item.exp[0]);
      end
    end
  end

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

    step(RT, 6'd0, 1'b0, 1'b1, E_FETCH_RST, "reset_fetch");

    step(LW, 6'd0, 1'b0, 1'b0, E_FETCH,  "lw_fetch");
    step(LW, 6'd0, 1'b0, 1'b0, E_DECODE, "lw_decode");
    step(LW, 6'd0, 1'b0, 1'b0, E_MEMADR, "lw_memadr");
    step(LW, 6'd0, 1'b0, 1'b0, E_MEMRD,  "lw_memrd");
    step(LW, 6'd0, 1'b0, 1'b0, E_MEMWB,  "lw_memwb");

    step(SW, 6'd0, 1'b1, 1'b0, E_FETCH,  "sw_fetch");
    step(SW, 6'd0, 1'b1, 1'b0, E_DECODE, "sw_decode");
    step(SW, 6'd0, 1'b1, 1'b0, E_MEMADR, "sw_memadr");
    step(SW, 6'd0, 1'b1, 1'b0, E_MEMWR,  "sw_memwr");

    step(RT, 6'b100010, 1'b0, 1'b0, E_FETCH,  "sub_fetch");
    step(RT, 6'b100010, 1'b0, 1'b0, E_DECODE, "sub_decode");
    step(RT, 6'b100010, 1'b0, 1'b0, E_EX_SUB, "sub_execute");
    step(RT, 6'b100010, 1'b0, 1'b0, E_ALUWB,  "sub_aluwb");

    step(RT, 6'b101010, 1'b0, 1'b0, E_FETCH,  "slt_fetch");
    step(RT, 6'b101010, 1'b0, 1'b0, E_DECODE, "slt_decode");
    step(RT, 6'b101010, 1'b0, 1'b0, E_EX_SLT, "slt_execute");
    step(RT, 6'b101010, 1'b0, 1'b0, E_ALUWB,  "slt_aluwb");

    step(RT, 6'b100100, 1'b0, 1'b0, E_FETCH,  "and_fetch");
    step(RT, 6'b100100, 1'b0, 1'b0, E_DECODE, "and_decode");
    step(RT, 6'b100100, 1'b0, 1'b0, E_EX_AND, "and_execute");
    step(RT, 6'b100100, 1'b0, 1'b0, E_ALUWB,  "and_aluwb");

    step(RT, 6'b000111, 1'b0, 1'b0, E_FETCH,   "badfunct_fetch");
    step(RT, 6'b000111, 1'b0, 1'b0, E_DECODE,  "badfunct_decode");
    step(RT, 6'b000111, 1'b0, 1'b0, E_EX_DFLT, "badfunct_execute");
    step(RT, 6'b000111, 1'b0, 1'b0, E_ALUWB,   "badfunct_aluwb");

    step(BEQ, 6'd0, 1'b1, 1'b0, E_FETCH,    "beq_t_fetch");
    step(BEQ, 6'd0, 1'b1, 1'b0, E_DECODE,   "beq_t_decode");
    step(BEQ, 6'd0, 1'b1, 1'b0, E_BR_TAKEN, "beq_taken");
    step(BEQ, 6'd0, 1'b0, 1'b0, E_FETCH,    "beq_n_fetch");
    step(BEQ, 6'd0, 1'b0, 1'b0, E_DECODE,   "beq_n_decode");
    step(BEQ, 6'd0, 1'b0, 1'b0, E_BR_NOT,   "beq_not_taken");
    step(BNE, 6'd0, 1'b0, 1'b0, E_FETCH,    "bne_t_fetch");
    step(BNE, 6'd0, 1'b0, 1'b0, E_DECODE,   "bne_t_decode");
    step(BNE, 6'd0, 1'b0, 1'b0, E_BR_TAKEN, "bne_taken");
    step(BNE, 6'd0, 1'b1, 1'b0, E_FETCH,    "bne_n_fetch");
    step(BNE, 6'd0, 1'b1, 1'b0, E_DECODE,   "bne_n_decode");
    step(BNE, 6'd0, 1'b1, 1'b0, E_BR_NOT,   "bne_not_taken");

    step(ADDI, 6'd0, 1'b0, 1'b0, E_FETCH,  "addi_fetch");
    step(ADDI, 6'd0, 1'b0, 1'b0, E_DECODE, "addi_decode");
    step(ADDI, 6'd0, 1'b0, 1'b0, E_ADDIEX, "addi_ex");
    step(ADDI, 6'd0, 1'b0, 1'b0, E_IMMWB,  "addi_immwb");

    step(ORI, 6'd0, 1'b0, 1'b0, E_FETCH,  "ori_fetch");
    step(ORI, 6'd0, 1'b0, 1'b0, E_DECODE, "ori_decode");
    step(ORI, 6'd0, 1'b0, 1'b0, E_ORIEX,  "ori_ex");
    step(ORI, 6'd0, 1'b0, 1'b0, E_IMMWB,  "ori_immwb");

    step(JMP, 6'd0, 1'b0, 1'b0, E_FETCH,  "j_fetch");
    step(JMP, 6'd0, 1'b0, 1'b0, E_DECODE, "j_decode");
    step(JMP, 6'd0, 1'b0, 1'b0, E_JUMP,   "j_jump");
    step(JMP, 6'd0, 1'b0, 1'b0, E_FETCH,  "j_back_fetch");

    step(BAD, 6'd0, 1'b0, 1'b0, E_DECODE, "bad_decode");
    for (int i = 0; i < 10; i++) step(BAD, 6'd0, 1'b1, 1'b0, E_HALT, "halt_hold");
    step(BAD, 6'd0, 1'b0, 1'b1, E_HALT,      "halt_reset_cycle");
    step(LW,  6'd0, 1'b0, 1'b1, E_FETCH_RST, "halt_reset_fetch");

    step(LW, 6'd0, 1'b0, 1'b0, E_FETCH,  "lwr_fetch");
    step(LW, 6'd0, 1'b0, 1'b0, E_DECODE, "lwr_decode");
    step(LW, 6'd0, 1'b0, 1'b0, E_MEMADR, "lwr_memadr");
    step(LW, 6'd0, 1'b0, 1'b1, E_MEMRD,  "lwr_reset_in_memrd");
    step(LW, 6'd0, 1'b0, 1'b0, E_FETCH,  "lwr_back_fetch");
    step(LW, 6'd0, 1'b0, 1'b0, E_DECODE, "lwr2_decode");
    step(LW, 6'd0, 1'b0, 1'b0, E_MEMADR, "lwr2_memadr");
    step(LW, 6'd0, 1'b0, 1'b0, E_MEMRD,  "lwr2_memrd");
    step(LW, 6'd0, 1'b0, 1'b1, E_MEMWB_RST, "lwr2_reset_in_memwb");

    step(SW, 6'd0, 1'b0, 1'b0, E_FETCH,  "swr_fetch");
    step(SW, 6'd0, 1'b0, 1'b0, E_DECODE, "swr_decode");
    step(SW, 6'd0, 1'b0, 1'b0, E_MEMADR, "swr_memadr");
    step(SW, 6'd0, 1'b0, 1'b1, E_MEMWR_RST, "swr_reset_in_memwr");
    step(SW, 6'd0, 1'b0, 1'b0, E_FETCH,  "swr_back_fetch");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
